tree_sum_accumulator: RTL and testbench

- Downstream stage of the 20-bit ripple-carry adder stage in the multi-operand binary tree adder.
- Consumes one (N+1)-bit partial sum per accepted beat and accumulates OPS consecutive beats into one frame total.
- Presents each frame total on a valid/ready output.
- Closes the tree when the last adder level is time-multiplexed instead of fully unrolled.

---
 rtl/tree_adder_pkg.sv | 18 +
 rtl/tree_acc_datapath.sv | 37 +++
 rtl/tree_sum_accumulator.sv | 108 ++++++++++
 tb/tb_tree_sum_accumulator.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tree_adder_pkg.sv
// Shared types and constants for the multi-operand binary tree adder stages.
package tree_adder_pkg;

  localparam int unsigned TREE_N   = 20;
  localparam int unsigned TREE_OPS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } tree_acc_state_t;

  // Width that holds the sum of ops unsigned (n+1)-bit operands without overflow.
  function automatic int unsigned accw(input int unsigned n, input int unsigned ops);
    return n + 1 + $clog2(ops);
  endfunction

endpackage

// File: rtl/tree_acc_datapath.sv
// Accumulator register, zero-extending adder and beat counter for tree_sum_accumulator.
module tree_acc_datapath
  import tree_adder_pkg::*;
#(
  parameter int unsigned N   = TREE_N,
  parameter int unsigned OPS = TREE_OPS,
  parameter int unsigned AW  = accw(N, OPS),
  parameter int unsigned CW  = $clog2(OPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          add,
  input  logic [N:0]    in_sum,
  output logic [AW-1:0] acc,
  output logic [CW-1:0] cnt
);

  // clear wins over load, load wins over add.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= AW'(in_sum);
      cnt <= CW'(1);
    end else if (add) begin
      acc <= acc + AW'(in_sum);
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates OPS partial sums per frame and presents the frame total on valid/ready.
// Optional abort input enabled by defining TREE_ACC_ABORT_EN.
module tree_sum_accumulator
  import tree_adder_pkg::*;
#(
  parameter int unsigned N   = TREE_N,
  parameter int unsigned OPS = TREE_OPS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N:0]               in_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [accw(N, OPS)-1:0]  out_total,
`ifdef TREE_ACC_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy
);

  localparam int unsigned ACCW = accw(N, OPS);
  localparam int unsigned CW   = $clog2(OPS + 1);
  localparam tree_acc_state_t FIRST_NEXT = (OPS == 1) ? HOLD : ACC;

  tree_acc_state_t state_q, state_d;
  logic            load, add, clear;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt;

  tree_acc_datapath #(
    .N   (N),
    .OPS (OPS),
    .AW  (ACCW),
    .CW  (CW)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .load   (load),
    .add    (add),
    .in_sum (in_sum),
    .acc    (acc),
    .cnt    (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake decode and datapath controls.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    add       = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = FIRST_NEXT;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          add = 1'b1;
          if (cnt == CW'(OPS - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          // Accepting while transferring starts the next frame without a bubble.
          if (in_valid) begin
            load    = 1'b1;
            state_d = FIRST_NEXT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef TREE_ACC_ABORT_EN
    // Abort drops any beat or transfer in flight this cycle.
    if (abort) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      add       = 1'b0;
      clear     = 1'b1;
      state_d   = IDLE;
    end
`endif
  end

  assign out_total = acc;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed self-checking bench for tree_sum_accumulator (N=20, OPS=8).
module tb_tree_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [20:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_total;
  logic        busy;
`ifdef TREE_ACC_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tree_sum_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
`ifdef TREE_ACC_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_total", 32'(out_total), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Max-value frame, contiguous, downstream always ready.
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 21'h1FFFFF;
    for (int i = 0; i < 7; i++) step();
    check("max_valid_after7", 32'(out_valid), 32'd0);
    check("max_busy_after7",  32'(busy),      32'd1);
    step();
    in_valid = 1'b0;
    check("max_valid", 32'(out_valid), 32'd1);
    check("max_total", 32'(out_total), 32'hFFFFF8);
    check("max_busy_hold", 32'(busy), 32'd0);
    step();
    check("max_idle_valid", 32'(out_valid), 32'd0);
    check("max_idle_busy",  32'(busy),      32'd0);
    check("max_idle_total", 32'(out_total), 32'hFFFFF8);

    // Beats 1..8 with a gap cycle between each.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_sum = 21'(i);
      step();
      in_valid = 1'b0; in_sum = 21'h155555;
      if (i < 8) begin
        check("gap_busy", 32'(busy), 32'd1);
        check("gap_acc",  32'(out_total), 32'(i * (i + 1) / 2));
        step();
        check("gap_acc_hold", 32'(out_total), 32'(i * (i + 1) / 2));
      end
    end
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_total", 32'(out_total), 32'd36);
    check("gap_busy_hold", 32'(busy), 32'd0);
    out_ready = 1'b1;
    step();
    check("gap_idle", 32'(out_valid), 32'd0);

    // 8x5 frame with downstream stalled for 4 cycles.
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 21'd5;
    for (int i = 0; i < 8; i++) step();
    in_sum = 21'd99;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_total",    32'(out_total), 32'd40);
      check("stall_in_ready", 32'(in_ready),  32'd0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("stall_idle_valid", 32'(out_valid), 32'd0);
    check("stall_idle_total", 32'(out_total), 32'd40);
    check("stall_idle_ready", 32'(in_ready),  32'd1);

    // Back-to-back frames: 8x2 then 7 followed by 7x1.
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 21'd2;
    for (int i = 0; i < 8; i++) step();
    check("b2b_first_total", 32'(out_total), 32'd16);
    check("b2b_first_ready", 32'(in_ready),  32'd1);
    in_sum = 21'd7;
    step();
    check("b2b_load_acc",   32'(out_total), 32'd7);
    check("b2b_load_valid", 32'(out_valid), 32'd0);
    check("b2b_load_busy",  32'(busy),      32'd1);
    in_sum = 21'd1;
    for (int i = 0; i < 6; i++) step();
    check("b2b_valid_after7", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_total", 32'(out_total), 32'd14);
    step();
    check("b2b_idle", 32'(out_valid), 32'd0);

    // Reset mid-frame after 3x100, with a beat presented on the reset edge.
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 21'd100;
    for (int i = 0; i < 3; i++) step();
    check("rstmid_acc", 32'(out_total), 32'd300);
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_busy",  32'(busy),      32'd0);
    check("rstmid_total", 32'(out_total), 32'd0);
    in_valid = 1'b1; in_sum = 21'd1;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    check("rstmid_frame_valid", 32'(out_valid), 32'd1);
    check("rstmid_frame_total", 32'(out_total), 32'd8);
    out_ready = 1'b1;
    step();
    check("rstmid_frame_idle", 32'(out_valid), 32'd0);

`ifdef TREE_ACC_ABORT_EN
    // Abort after 5x3, then a clean 8x2 frame, then abort against a HOLD transfer.
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 21'd3;
    for (int i = 0; i < 5; i++) step();
    check("abort_acc", 32'(out_total), 32'd15);
    abort = 1'b1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_total", 32'(out_total), 32'd0);
    in_valid = 1'b1; in_sum = 21'd2;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    check("abort_frame_total", 32'(out_total), 32'd16);
    out_ready = 1'b1; abort = 1'b1;
    check("abort_hold_valid", 32'(out_valid), 32'd0);
    step();
    abort = 1'b0;
    check("abort_hold_idle",  32'(out_valid), 32'd0);
    check("abort_hold_total", 32'(out_total), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
